imem_access_arbiter: RTL and testbench

- Arbitrates one single-port, synchronous-read instruction memory between two requesters:
  - the core fetch stage (read-only);
  - the program loader (write-only; fills the memory after reset or on debug reload).
- Sits between the fetch stage, the loader and the instruction memory macro.
- Owns the memory enable, write-enable and word-address generation.
- Returns fetch data with fixed one-cycle latency.
- Flags misaligned or out-of-range fetches without touching memory.

---
 rtl/imem_access_arbiter_if.sv | 30 +++
 rtl/imem_access_arbiter.sv | 66 ++++++
 tb/tb_imem_access_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_access_arbiter_if.sv
// imem_access_arbiter_if: fetch, loader and memory-macro signals of the instruction memory arbiter.
interface imem_access_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              fetch_req_i;
  logic [31:0]       fetch_addr_i;
  logic              fetch_gnt_o;
  logic              fetch_rvalid_o;
  logic [31:0]       fetch_rdata_o;
  logic              fetch_err_o;
  logic              load_req_i;
  logic [31:0]       load_addr_i;
  logic [31:0]       load_wdata_i;
  logic              load_gnt_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  modport slave (
    input  fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_wdata_i, mem_rdata_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o, load_gnt_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
  modport master (
    output fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_wdata_i, mem_rdata_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o, load_gnt_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares one sync-read instruction memory between fetch (read) and loader (write).
module imem_access_arbiter #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MAX_BURST = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  imem_access_arbiter_if.slave bus
);
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [3:0]  MAXB = 4'(MAX_BURST);
  logic [3:0]        r_burst_cnt;
  logic              r_resp_pending;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              w_fetch_legal;
  logic              w_load_legal;
  logic              w_fetch_gnt;
  logic              w_load_gnt;
  logic              w_fetch_en;
  logic              w_load_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [3:0]        w_burst_nxt;
  function automatic logic legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && {2'b00, a[31:2]} < 32'(DEPTH);
  endfunction
  // Grants are forced low while reset is asserted, even with requests pending.
  always_comb begin
    w_fetch_legal = legal(bus.fetch_addr_i);
    w_load_legal  = legal(bus.load_addr_i);
    w_load_gnt    = rst_ni && bus.load_req_i && !(bus.fetch_req_i && r_burst_cnt == MAXB);
    w_fetch_gnt   = rst_ni && bus.fetch_req_i && !w_load_gnt;
    w_load_en     = w_load_gnt && w_load_legal;
    w_fetch_en    = w_fetch_gnt && w_fetch_legal;
    w_mem_addr    = w_load_en  ? bus.load_addr_i[ADDR_W+1:2] :
                    w_fetch_en ? bus.fetch_addr_i[ADDR_W+1:2] : r_mem_addr;
    w_burst_nxt   = (!bus.fetch_req_i || w_fetch_gnt) ? 4'd0 :
                    (w_load_gnt && r_burst_cnt < MAXB) ? r_burst_cnt + 4'd1 : r_burst_cnt;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_burst_cnt    <= '0;
      r_resp_pending <= 1'b0;
      r_resp_err     <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_burst_cnt    <= w_burst_nxt;
      r_resp_pending <= w_fetch_gnt;
      r_resp_err     <= w_fetch_gnt && !w_fetch_legal;
      if (w_load_en || w_fetch_en) r_mem_addr <= w_mem_addr;
      if (w_load_en) r_mem_wdata <= bus.load_wdata_i;
    end
  end
  assign bus.fetch_gnt_o    = w_fetch_gnt;
  assign bus.load_gnt_o     = w_load_gnt;
  assign bus.mem_en_o       = w_load_en || w_fetch_en;
  assign bus.mem_we_o       = w_load_en;
  assign bus.mem_addr_o     = w_mem_addr;
  assign bus.mem_wdata_o    = w_load_en ? bus.load_wdata_i : r_mem_wdata;
  assign bus.fetch_rvalid_o = r_resp_pending;
  assign bus.fetch_err_o    = r_resp_err;
  assign bus.fetch_rdata_o  = !r_resp_pending ? 32'h0 : r_resp_err ? NOP : bus.mem_rdata_i;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter: table-driven vectors plus hand-written burst and reset sequences.
module tb_imem_access_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem [64];
  imem_access_arbiter_if #(.ADDR_W(6)) bus();
  imem_access_arbiter #(.DEPTH(64), .MAX_BURST(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      else bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  typedef struct {
    logic fr; logic [31:0] fa; logic lr; logic [31:0] la; logic [31:0] lw;
    logic fg; logic lg; logic en; logic we; logic [5:0] ma; logic [31:0] mw;
    logic rv; logic er; logic [31:0] rd;
  } vec_t;
  vec_t v [11];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [31:0] la, input logic [31:0] lw);
    bus.fetch_req_i  = fr;
    bus.fetch_addr_i = fa;
    bus.load_req_i   = lr;
    bus.load_addr_i  = la;
    bus.load_wdata_i = lw;
  endtask
  task automatic burst(input string n, input logic fr, input logic lr, input logic ef, input logic el);
    @(negedge clk);
    drive(fr, 32'hC, lr, 32'h20, 32'h55AA_0000);
    #1;
    chk({n, "_fgnt"}, 32'(bus.fetch_gnt_o), 32'(ef));
    chk({n, "_lgnt"}, 32'(bus.load_gnt_o), 32'(el));
  endtask
  initial begin
    string pat;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    v[0]  = '{1'b1, 32'h0,   1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0,         1'b0, 1'b0, 32'h0};
    v[1]  = '{1'b1, 32'h4,   1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 32'h0,         1'b1, 1'b0, 32'h0050_0093};
    v[2]  = '{1'b1, 32'h8,   1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 32'h0,         1'b1, 1'b0, 32'h00A0_0113};
    v[3]  = '{1'b0, 32'h0,   1'b1, 32'h10,  32'hDEAD_BEEF,  1'b0, 1'b1, 1'b1, 1'b1, 6'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0020_81B3};
    v[4]  = '{1'b1, 32'h10,  1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    v[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
    v[6]  = '{1'b1, 32'h6,   1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    v[7]  = '{1'b1, 32'h100, 1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h13};
    v[8]  = '{1'b0, 32'h0,   1'b1, 32'h200, 32'h1234_5678,  1'b0, 1'b1, 1'b0, 1'b0, 6'd4, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h13};
    v[9]  = '{1'b1, 32'h0,   1'b0, 32'h0,   32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    v[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0050_0093};
    drive(1'b1, 32'h10, 1'b1, 32'h10, 32'hFFFF_FFFF);
    #2;
    chk("rst_rvalid", 32'(bus.fetch_rvalid_o), 32'h0);
    chk("rst_err",    32'(bus.fetch_err_o),    32'h0);
    chk("rst_rdata",  bus.fetch_rdata_o,       32'h0);
    chk("rst_fgnt",   32'(bus.fetch_gnt_o),    32'h0);
    chk("rst_lgnt",   32'(bus.load_gnt_o),     32'h0);
    chk("rst_en",     32'(bus.mem_en_o),       32'h0);
    chk("rst_we",     32'(bus.mem_we_o),       32'h0);
    chk("rst_addr",   32'(bus.mem_addr_o),     32'h0);
    chk("rst_wdata",  bus.mem_wdata_o,         32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(v[i].fr, v[i].fa, v[i].lr, v[i].la, v[i].lw);
      #1;
      chk($sformatf("v%0d_fgnt", i),   32'(bus.fetch_gnt_o),    32'(v[i].fg));
      chk($sformatf("v%0d_lgnt", i),   32'(bus.load_gnt_o),     32'(v[i].lg));
      chk($sformatf("v%0d_en", i),     32'(bus.mem_en_o),       32'(v[i].en));
      if (v[i].en) chk($sformatf("v%0d_we", i), 32'(bus.mem_we_o), 32'(v[i].we));
      chk($sformatf("v%0d_addr", i),   32'(bus.mem_addr_o),     32'(v[i].ma));
      chk($sformatf("v%0d_wdata", i),  bus.mem_wdata_o,         v[i].mw);
      chk($sformatf("v%0d_rvalid", i), 32'(bus.fetch_rvalid_o), 32'(v[i].rv));
      if (v[i].rv) begin
        chk($sformatf("v%0d_err", i),   32'(bus.fetch_err_o), 32'(v[i].er));
        chk($sformatf("v%0d_rdata", i), bus.fetch_rdata_o,    v[i].rd);
      end
    end
    // Both requesting: four loader grants, then one fetch, repeating.
    pat = "LLLLFLLLLF";
    for (int k = 0; k < 10; k++) begin
      burst($sformatf("starve%0d", k), 1'b1, 1'b1, pat[k] == "F", pat[k] == "L");
      chk($sformatf("starve%0d_rvalid", k), 32'(bus.fetch_rvalid_o), 32'(k > 0 && pat[k-1] == "F"));
      if (k > 0 && pat[k-1] == "F") chk($sformatf("starve%0d_rdata", k), bus.fetch_rdata_o, 32'hA000_0003);
    end
    burst("post_starve", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_starve_rvalid", 32'(bus.fetch_rvalid_o), 32'h1);
    chk("post_starve_rdata",  bus.fetch_rdata_o,       32'hA000_0003);
    for (int k = 0; k < 3; k++) burst($sformatf("pre%0d", k), 1'b1, 1'b1, 1'b0, 1'b1);
    burst("load_only", 1'b0, 1'b1, 1'b0, 1'b1);
    pat = "LLLLF";
    for (int k = 0; k < 5; k++) burst($sformatf("clr%0d", k), 1'b1, 1'b1, pat[k] == "F", pat[k] == "L");
    @(negedge clk);
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    #1;
    chk("mid_fgnt", 32'(bus.fetch_gnt_o), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.fetch_rvalid_o), 32'h0);
    chk("mid_rst_fgnt",   32'(bus.fetch_gnt_o),    32'h0);
    chk("mid_rst_en",     32'(bus.mem_en_o),       32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_rvalid0", 32'(bus.fetch_rvalid_o), 32'h0);
    @(negedge clk);
    #1;
    chk("rel_rvalid1", 32'(bus.fetch_rvalid_o), 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    #1;
    chk("post_rst_fgnt", 32'(bus.fetch_gnt_o), 32'h1);
    chk("post_rst_addr", 32'(bus.mem_addr_o),  32'h2);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("post_rst_rvalid", 32'(bus.fetch_rvalid_o), 32'h1);
    chk("post_rst_err",    32'(bus.fetch_err_o),    32'h0);
    chk("post_rst_rdata",  bus.fetch_rdata_o,       32'h0020_81B3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
